// File: rtl/uart_txq_pkg.sv
// Shared types and defaults for the UART transmit queue.
// State encoding, byte width, default FIFO depth and ack timeout.
package uart_txq_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_AW          = 4;
    localparam int DEF_ACK_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/uart_txq_fifo.sv
// DEPTH x 8 byte FIFO with wrap-around pointers and occupancy count.
// Ports: wr_en_i/wr_data_i push, rd_en_i pops head rd_data_o; full_o, empty_o, count_o.
module uart_txq_fifo
    import uart_txq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_wr, do_rd;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    assign rd_data_o = mem[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_wr) wptr_q <= wptr_q + AW'(1);
            if (do_rd) rptr_q <= rptr_q + AW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART parallel write port with a level wr/ack handshake.
// Ports: push/push_data in; full/empty/count/ovf/tmo status; clr clears stickies;
// uart_data/uart_wr/uart_ce out, uart_dbf in (async). Macro UART_TXQ_STATS_EN adds tx_cnt.
module uart_tx_queue
    import uart_txq_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = DEF_AW,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              ovf,
    output logic              tmo,
    input  logic              clr,
    output logic [BYTE_W-1:0] uart_data,
    output logic              uart_wr,
    output logic              uart_ce,
    input  logic              uart_dbf
`ifdef UART_TXQ_STATS_EN
    ,
    output logic [15:0]       tx_cnt
`endif
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] data_q, data_d, head;
    logic              wr_q, wr_d, ce_q, ce_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              ovf_q, ovf_d, tmo_q, tmo_d;
    logic              sync1_q, dbf_s_q;
    logic              pop, tmo_set, ovf_set;

    uart_txq_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (push),
        .wr_data_i(push_data),
        .rd_en_i  (pop),
        .rd_data_o(head),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count)
    );

    assign uart_data = data_q;
    assign uart_wr   = wr_q;
    assign uart_ce   = ce_q;
    assign ovf       = ovf_q;
    assign tmo       = tmo_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        wr_d    = wr_q;
        ce_d    = ce_q;
        tcnt_d  = tcnt_q;
        pop     = 1'b0;
        tmo_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !dbf_s_q) begin
                    pop     = 1'b1;
                    data_d  = head;
                    ce_d    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wr_d    = 1'b1;
                tcnt_d  = '0;
                state_d = REQ;
            end
            REQ: begin
                if (dbf_s_q) begin
                    wr_d    = 1'b0;
                    state_d = DRAIN;
                end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
                    // wr has now been held for ACK_TIMEOUT cycles
                    tmo_set = 1'b1;
                    wr_d    = 1'b0;
                    ce_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            DRAIN: begin
                if (!dbf_s_q) begin
                    ce_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Full-and-popping is a legal push, not an overflow.
    assign ovf_set = push && full && !pop;
    assign ovf_d   = (ovf_q && !clr) || ovf_set;
    assign tmo_d   = (tmo_q && !clr) || tmo_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            wr_q    <= 1'b0;
            ce_q    <= 1'b0;
            tcnt_q  <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            sync1_q <= 1'b0;
            dbf_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            ce_q    <= ce_d;
            tcnt_q  <= tcnt_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            sync1_q <= uart_dbf;
            dbf_s_q <= sync1_q;
        end
    end

`ifdef UART_TXQ_STATS_EN
    logic [15:0] txc_q, txc_d;
    logic        acc;

    assign acc    = (state_q == REQ) && dbf_s_q;
    assign tx_cnt = txc_q;

    always_comb begin
        txc_d = clr ? 16'h0 : txc_q;
        if (acc) txc_d = txc_q + 16'h1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txc_q <= '0;
        end else begin
            txc_q <= txc_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a handshaking UART model and scoreboard.
// Ports driven: all DUT ports; tx_cnt checked when UART_TXQ_STATS_EN is defined.
module tb_uart_tx_queue;

    localparam int DEPTH  = 16;
    localparam int M_AUTO = 0;
    localparam int M_LO   = 1;
    localparam int M_HI   = 2;

    logic       clk = 1'b0;
    logic       rst, push, clr, uart_dbf;
    logic [7:0] push_data;
    logic       full, empty, ovf, tmo, uart_wr, uart_ce;
    logic [4:0] count;
    logic [7:0] uart_data;
`ifdef UART_TXQ_STATS_EN
    logic [15:0] tx_cnt;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    int         mode  = M_LO;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_queue dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf),
        .tmo      (tmo),
        .clr      (clr),
        .uart_data(uart_data),
        .uart_wr  (uart_wr),
        .uart_ce  (uart_ce),
        .uart_dbf (uart_dbf)
`ifdef UART_TXQ_STATS_EN
        ,
        .tx_cnt   (tx_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: while wr is asserted the bus must carry the oldest unsent byte.
    always @(negedge clk) begin
        if (!rst) begin
            chk("full_vs_count", full, count == 5'd16);
            chk("empty_vs_count", empty, count == 5'd0);
            if (uart_wr) begin
                chk("ce_during_wr", uart_ce, 1);
                if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("uart_data", uart_data, exp_q[0]);
            end
        end
    end

    // UART model: auto mode raises dbf 5 cycles after wr, holds 30 cycles.
    initial begin
        int hs_cnt;
        bit busy, got;
        uart_dbf = 1'b0;
        hs_cnt   = 0;
        busy     = 0;
        got      = 0;
        forever begin
            @(negedge clk);
            if (mode == M_HI) begin
                uart_dbf = 1'b1; busy = 0; hs_cnt = 0; got = 0;
            end else if (mode == M_LO) begin
                uart_dbf = 1'b0; busy = 0; hs_cnt = 0; got = 0;
            end else if (!uart_dbf) begin
                if (uart_wr) begin
                    hs_cnt++;
                    if (hs_cnt == 5) begin
                        uart_dbf = 1'b1; busy = 1; hs_cnt = 0;
                    end
                end else hs_cnt = 0;
            end else if (!busy) begin
                uart_dbf = 1'b0;
            end else begin
                if (!uart_wr && !got) begin
                    got = 1;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                hs_cnt++;
                if (hs_cnt == 30) begin
                    chk("wr_dropped_on_ack", got, 1);
                    uart_dbf = 1'b0; busy = 0; got = 0; hs_cnt = 0;
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit acc);
        push      = 1'b1;
        push_data = b;
        if (acc) exp_q.push_back(b);
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic wait_wr(input logic lvl, input int lim, input string nm);
        int n = 0;
        while (uart_wr !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, uart_wr, lvl);
    endtask

    task automatic wait_ce_low(input int lim, input string nm);
        int n = 0;
        while (uart_ce !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, uart_ce, 0);
    endtask

    task automatic wait_drain(input int lim, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wr_width(input int lim, output int w);
        w = 1;
        while (uart_wr && w < lim) begin
            @(negedge clk);
            if (uart_wr) w++;
        end
    endtask

    initial begin
        int w;
        rst = 1'b1; push = 1'b0; push_data = 8'h00; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_wr", uart_wr, 0);
        chk("rst_ce", uart_ce, 0);
        chk("rst_data", uart_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Reset while a request is outstanding
        mode = M_LO;
        push_byte(8'hA5, 1);
        wait_wr(1, 20, "rreq_wr_rise");
        rst = 1'b1;
        #1;
        chk("rreq_wr", uart_wr, 0);
        chk("rreq_ce", uart_ce, 0);
        chk("rreq_count", count, 0);
        chk("rreq_empty", empty, 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rreq_idle_wr", uart_wr, 0);
        chk("rreq_idle_ce", uart_ce, 0);

        // Single byte: ce after pop, wr two cycles after push
        mode = M_AUTO;
        push_byte(8'h3C, 1);
        chk("single_ce_early", uart_ce, 0);
        @(negedge clk);
        chk("single_ce_setup", uart_ce, 1);
        chk("single_wr_setup", uart_wr, 0);
        @(negedge clk);
        chk("single_wr_rise", uart_wr, 1);
        chk("single_data", uart_data, 8'h3C);
        wr_width(100, w);
        chk("single_wr_width", w, 7);
        chk("single_ce_drain", uart_ce, 1);
        wait_ce_low(60, "single_ce_low");
        chk("single_empty", empty, 1);
        chk("single_sent", exp_q.size(), 0);

        // Fill to DEPTH with the UART busy, then overflow once
        mode = M_HI;
        repeat (4) @(negedge clk);
        for (int i = 0; i <= DEPTH; i++) push_byte(8'(i), i < DEPTH);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_ovf", ovf, 1);
        chk("fill_ce", uart_ce, 0);
        pulse_clr();
        chk("fill_ovf_clr", ovf, 0);
        mode = M_AUTO;
        wait_drain(2500, "fill_drain");
        wait_ce_low(60, "fill_ce_low");
        chk("fill_empty", empty, 1);
        chk("fill_ovf_after", ovf, 0);

        // Ack timeout discards the byte; next byte goes through
        mode = M_LO;
        repeat (3) @(negedge clk);
        push_byte(8'h5A, 1);
        wait_wr(1, 20, "tmo_wr_rise");
        wr_width(400, w);
        chk("tmo_wr_width", w, 255);
        chk("tmo_flag", tmo, 1);
        chk("tmo_wr", uart_wr, 0);
        chk("tmo_ce", uart_ce, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mode = M_AUTO;
        push_byte(8'h77, 1);
        wait_drain(200, "tmo_next_byte");
        wait_ce_low(60, "tmo_ce_low");
        chk("tmo_sticky", tmo, 1);
        pulse_clr();
        chk("tmo_clr", tmo, 0);

        // Push coinciding with a pop while full
        mode = M_HI;
        repeat (4) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i), 1);
        chk("spp_full", full, 1);
        chk("spp_ovf0", ovf, 0);
        @(posedge clk);
        #1 mode = M_AUTO;
        repeat (3) @(negedge clk);
        push_byte(8'hEE, 1);
        chk("spp_count", count, 16);
        chk("spp_ovf", ovf, 0);
        chk("spp_ce", uart_ce, 1);
        wait_drain(3000, "spp_drain");
        wait_ce_low(60, "spp_ce_low");
        chk("spp_empty", empty, 1);

`ifdef UART_TXQ_STATS_EN
        pulse_clr();
        chk("stats_clr0", tx_cnt, 0);
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i), 1);
        wait_drain(500, "stats_drain");
        wait_ce_low(60, "stats_ce_low");
        mode = M_LO;
        repeat (3) @(negedge clk);
        push_byte(8'hD0, 1);
        wait_wr(1, 20, "stats_tmo_rise");
        wait_wr(0, 400, "stats_tmo_fall");
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("stats_tmo", tmo, 1);
        chk("stats_cnt3", tx_cnt, 3);
        pulse_clr();
        chk("stats_clr", tx_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
